bin2bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter for the digital clock display path.
- Generalises the fixed 6-bit tens/ones split to any input width and digit count.
- Uses iterative shift-add-3 (double dabble), one input bit per clock.
- Start/done handshake, registered outputs, and an overflow flag for values that do not fit in DIGITS BCD digits.

---
 rtl/bin2bcd_seq.sv | 105 ++++++++++
 tb/tb_bin2bcd_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble), one input bit per clock.
// A start/done handshake frames each conversion. bcd and overflow are registered and hold
// their values until the next done pulse.
// Optional build macro BIN2BCD_SATURATE_EN: on overflow, bcd loads all-nines instead of the
// truncated low digits.
module bin2bcd_seq #(
   parameter int unsigned IN_W   = 6,
   parameter int unsigned DIGITS = 2,
   parameter int unsigned CNT_W  = $clog2(IN_W + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [IN_W-1:0]       data,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int unsigned BW = 4 * DIGITS;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q;
   logic [IN_W-1:0]  shreg_q;
   logic [BW-1:0]    scr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;

   logic [BW-1:0]    adj;
   logic [BW-1:0]    scr_next;
   logic [IN_W-1:0]  shreg_next;
   logic             ovf_next;
   logic [BW-1:0]    bcd_load;

   // One double-dabble step: add 3 to digits >= 5, then shift {scratch, shreg} left by one.
   always_comb begin
      adj = scr_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
         end
      end
      // The top digit's MSB leaving the scratch register is a carry into a digit we lack.
      ovf_next   = ovf_q | adj[BW-1];
      scr_next   = {adj[BW-2:0], shreg_q[IN_W-1]};
      shreg_next = shreg_q << 1;
`ifdef BIN2BCD_SATURATE_EN
      bcd_load   = ovf_next ? {DIGITS{4'h9}} : scr_next;
`else
      bcd_load   = scr_next;
`endif
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         shreg_q  <= '0;
         scr_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  shreg_q <= data;
                  scr_q   <= '0;
                  ovf_q   <= 1'b0;
                  cnt_q   <= CNT_W'(IN_W);
                  busy    <= 1'b1;
                  state_q <= StShift;
               end
            end
            StShift: begin
               scr_q   <= scr_next;
               shreg_q <= shreg_next;
               ovf_q   <= ovf_next;
               cnt_q   <= cnt_q - CNT_W'(1);
               // Last shift: publish the result on the same edge that enters DONE.
               if (cnt_q == CNT_W'(1)) begin
                  state_q  <= StDone;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  bcd      <= bcd_load;
                  overflow <= ovf_next;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: three instances (6b/2d, 8b/2d, 14b/4d) share clock,
// reset and data; a select picks which one receives start and is observed.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [13:0] data = '0;
   int          sel = 0;

   logic        start_a, start_b, start_c;
   logic        busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c;
   logic [7:0]  bcd_a, bcd_b;
   logic [15:0] bcd_c;
   logic        ovf_a, ovf_b, ovf_c;

   logic        busy_o, done_o, ovf_o;
   logic [15:0] bcd_o;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign start_a = start && (sel == 0);
   assign start_b = start && (sel == 1);
   assign start_c = start && (sel == 2);

   bin2bcd_seq #(.IN_W(6), .DIGITS(2)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .data(data[5:0]),
      .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
   );
   bin2bcd_seq #(.IN_W(8), .DIGITS(2)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .data(data[7:0]),
      .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
   );
   bin2bcd_seq #(.IN_W(14), .DIGITS(4)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .data(data),
      .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c)
   );

   always_comb begin
      busy_o = busy_a; done_o = done_a; bcd_o = {8'h00, bcd_a}; ovf_o = ovf_a;
      if (sel == 1) begin
         busy_o = busy_b; done_o = done_b; bcd_o = {8'h00, bcd_b}; ovf_o = ovf_b;
      end else if (sel == 2) begin
         busy_o = busy_c; done_o = done_c; bcd_o = bcd_c; ovf_o = ovf_c;
      end
   end

   function automatic int in_w(input int c);
      return (c == 0) ? 6 : (c == 1) ? 8 : 14;
   endfunction

   function automatic int n_dig(input int c);
      return (c == 2) ? 4 : 2;
   endfunction

   function automatic logic ref_ovf(input int v, input int d);
      int m;
      m = 1;
      for (int i = 0; i < d; i++) m = m * 10;
      return v >= m;
   endfunction

   // Decimal digits of v, packed four bits per digit, ones digit lowest.
   function automatic logic [15:0] ref_bcd(input int v, input int d);
      int m;
      int x;
      logic [15:0] r;
      m = 1;
      for (int i = 0; i < d; i++) m = m * 10;
      r = '0;
`ifdef BIN2BCD_SATURATE_EN
      if (v >= m) begin
         for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
         return r;
      end
`endif
      x = v % m;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Issue one start and follow it to done (bounded). lat = samples after the start edge
   // until done is seen (-1 on timeout); done_after = done one cycle after the pulse.
   task automatic run_conv(input int c, input int v, output logic [15:0] b, output logic o,
                           output int lat, output int busy_cnt, output logic done_after);
      sel = c;
      data = 14'(v);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      data = 14'($urandom);
      lat = -1;
      busy_cnt = 0;
      b = '0;
      o = 1'b0;
      done_after = 1'bx;
      for (int n = 0; n < 40; n++) begin
         if (done_o) begin
            lat = n;
            b = bcd_o;
            o = ovf_o;
            break;
         end
         if (busy_o) busy_cnt++;
         @(posedge clk); #1;
      end
      if (lat >= 0) begin
         @(posedge clk); #1;
         done_after = done_o;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
         sel = c;
         #0;
         vectors++;
         if ({busy_o, done_o, ovf_o, bcd_o} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset cfg%0d: busy=%b done=%b ovf=%b bcd=%h, required all zero",
                     c, busy_o, done_o, ovf_o, bcd_o);
         end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [15:0] b; logic o; int lat; int bc; logic da;
      run_conv(0, 45, b, o, lat, bc, da);
      vectors++;
      if (lat !== 6 || bc !== 6 || da !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_timing: lat=%0d busy=%0d done_after=%b, required 6 6 0", lat, bc, da);
      end
      vectors++;
      if (b !== 16'h0045 || o !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_value: bcd=%h ovf=%b, required 0045 0", b, o);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] b; logic o; int lat; int bc; logic da;
      for (int v = 0; v < 64; v++) begin
         run_conv(0, v, b, o, lat, bc, da);
         vectors++;
         if (lat !== 6 || b !== ref_bcd(v, 2) || o !== 1'b0 || da !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep %0d: bcd=%h ovf=%b lat=%0d done_after=%b, required %h 0 6 0",
                     v, b, o, lat, da, ref_bcd(v, 2));
         end
      end
   endtask

   task automatic test_overflow();
      logic [15:0] b; logic o; int lat; int bc; logic da;
      int v;
      for (int k = 0; k < 24; k++) begin
         v = (k == 0) ? 200 : (k == 1) ? 99 : (k == 2) ? 255 : (k == 3) ? 100
                            : int'($urandom_range(0, 255));
         run_conv(1, v, b, o, lat, bc, da);
         vectors++;
         if (lat !== 8 || b !== ref_bcd(v, 2) || o !== ref_ovf(v, 2)) begin
            miscompares++;
            $display("FAIL overflow %0d: bcd=%h ovf=%b lat=%0d, required %h %b 8",
                     v, b, o, lat, ref_bcd(v, 2), ref_ovf(v, 2));
         end
      end
      // Results hold while idle.
      repeat (5) @(posedge clk);
      #1;
      vectors++;
      if (bcd_o !== b || ovf_o !== o || done_o !== 1'b0) begin
         miscompares++;
         $display("FAIL hold: bcd=%h ovf=%b done=%b, required %h %b 0", bcd_o, ovf_o, done_o, b, o);
      end
   endtask

   task automatic test_protocol();
      int dcount;
      logic [15:0] b;
      sel = 0;
      data = 14'd12;
      start = 1'b1;
      @(posedge clk); #1;
      dcount = 0;
      b = '0;
      for (int n = 0; n < 25; n++) begin
         if (done_o) begin
            dcount++;
            b = bcd_o;
         end
         // Extra starts during SHIFT and in the DONE cycle must be ignored.
         start = (n == 2) || done_o;
         data = start ? 14'd34 : 14'd50;
         @(posedge clk); #1;
      end
      start = 1'b0;
      vectors++;
      if (dcount !== 1 || b !== 16'h0012) begin
         miscompares++;
         $display("FAIL protocol: dones=%0d bcd=%h, required 1 0012", dcount, b);
      end
      vectors++;
      if (bcd_o !== 16'h0012) begin
         miscompares++;
         $display("FAIL protocol_hold: bcd=%h, required 0012", bcd_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] b; logic o; int lat; int bc; logic da;
      int dcount;
      sel = 0;
      data = 14'd37;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({busy_o, done_o, ovf_o, bcd_o} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset_mid: busy=%b done=%b ovf=%b bcd=%h, required all zero",
                  busy_o, done_o, ovf_o, bcd_o);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      dcount = 0;
      for (int n = 0; n < 12; n++) begin
         if (done_o || busy_o) dcount++;
         @(posedge clk); #1;
      end
      vectors++;
      if (dcount !== 0) begin
         miscompares++;
         $display("FAIL reset_abort: activity=%0d cycles, required 0", dcount);
      end
      run_conv(0, 21, b, o, lat, bc, da);
      vectors++;
      if (lat !== 6 || b !== 16'h0021 || o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_restart: bcd=%h ovf=%b lat=%0d, required 0021 0 6", b, o, lat);
      end
   endtask

   task automatic test_wide();
      logic [15:0] b; logic o; int lat; int bc; logic da;
      int v;
      for (int k = 0; k < 24; k++) begin
         v = (k == 0) ? 9999 : (k == 1) ? 16383 : (k == 2) ? 10000 : (k == 3) ? 0
                             : int'($urandom_range(0, 16383));
         run_conv(2, v, b, o, lat, bc, da);
         vectors++;
         if (lat !== 14 || bc !== 14 || b !== ref_bcd(v, 4) || o !== ref_ovf(v, 4)) begin
            miscompares++;
            $display("FAIL wide %0d: bcd=%h ovf=%b lat=%0d busy=%0d, required %h %b 14 14",
                     v, b, o, lat, bc, ref_bcd(v, 4), ref_ovf(v, 4));
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] b; logic o; int lat; int bc; logic da;
      int c;
      int v;
      for (int k = 0; k < 40; k++) begin
         c = int'($urandom_range(0, 2));
         v = int'($urandom_range(0, (1 << in_w(c)) - 1));
         run_conv(c, v, b, o, lat, bc, da);
         vectors++;
         if (lat !== in_w(c) || b !== ref_bcd(v, n_dig(c)) || o !== ref_ovf(v, n_dig(c))) begin
            miscompares++;
            $display("FAIL random cfg%0d %0d: bcd=%h ovf=%b lat=%0d, required %h %b %0d",
                     c, v, b, o, lat, ref_bcd(v, n_dig(c)), ref_ovf(v, n_dig(c)), in_w(c));
         end
         repeat (int'($urandom_range(0, 2))) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_overflow();
      test_protocol();
      test_reset_mid();
      test_wide();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
